// File: rtl/uc_pila.sv
// ----------------------------------------------------------------------------
// uc_pila: control unit for the single-cycle datapath (PC, register bank, ALU).
// Decodes opcode[3:0] into datapath controls with zero latency, and adds
// CALL/RET through an internal return-address stack guarded by overflow and
// underflow detection. A small RUN/HALT/ERR state machine stops the processor
// on HALT or on a stack fault; only reset brings it back to RUN.
// ----------------------------------------------------------------------------
module uc_pila #(
    parameter  int OPW   = 6,                  // opcode width, only [3:0] decoded
    parameter  int AW    = 10,                 // PC / address width
    parameter  int DEPTH = 4,                  // return-stack entries
    localparam int SPW   = $clog2(DEPTH + 1)   // stack pointer width, 0..DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           z,
    input  logic [OPW-1:0] opcode,
    input  logic [AW-1:0]  pc_next,
    output logic           s_inc,
    output logic           s_inm,
    output logic           we3,
    output logic [2:0]     op,
    output logic           s_ret,
    output logic [AW-1:0]  ret_addr,
    output logic           pc_en,
    output logic           fin,
    output logic           err_pila,
    output logic [SPW-1:0] nivel
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_HALT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
    localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

    // Opcode field groups decoded on opcode[3:0]
    localparam logic [3:0] OPC_LOAD = 4'b1000;
    localparam logic [3:0] OPC_JMP  = 4'b1001;
    localparam logic [3:0] OPC_JZ   = 4'b1010;
    localparam logic [3:0] OPC_JNZ  = 4'b1011;
    localparam logic [3:0] OPC_CALL = 4'b1100;
    localparam logic [3:0] OPC_RET  = 4'b1101;
    localparam logic [3:0] OPC_NOP  = 4'b1110;

    state_t         st;
    state_t         st_next;
    logic [SPW-1:0] sp;
    logic [AW-1:0]  stack [DEPTH];
    logic           push;
    logic           pop;
    logic [3:0]     opc;

    assign opc   = opcode[3:0];
    assign nivel = sp;

    // Upper opcode bits carry no meaning for this control unit.
    generate
        if (OPW > 4) begin : g_opcode_hi
            logic unused_opcode_hi;
            assign unused_opcode_hi = ^opcode[OPW-1:4];
        end
    endgenerate

    // Instruction decode, stack requests and next-state selection.
    always_comb begin
        // NOTE: every output of this block gets a value before any branch, so
        // no path through the case can leave a signal holding (no latch).
        s_inc    = 1'b1;
        s_inm    = 1'b0;
        we3      = 1'b0;
        op       = 3'b000;
        s_ret    = 1'b0;
        pc_en    = 1'b1;
        fin      = 1'b0;
        err_pila = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        st_next  = st;

        if (reset) begin
            // Hold the PC while reset is applied; everything else idles.
            pc_en = 1'b0;
        end else begin
            case (st)
                ST_RUN: begin
                    casez (opc)
                        4'b0???: begin
                            we3 = 1'b1;
                            op  = opcode[2:0];
                        end
                        OPC_LOAD: begin
                            we3   = 1'b1;
                            s_inm = 1'b1;
                        end
                        OPC_JMP: s_inc = 1'b0;
                        OPC_JZ:  s_inc = ~z;
                        OPC_JNZ: s_inc = z;
                        OPC_CALL: begin
                            if (sp < SP_FULL) begin
                                s_inc = 1'b0;
                                push  = 1'b1;
                            end else begin
                                // Overflow: freeze PC and report in this cycle.
                                pc_en    = 1'b0;
                                fin      = 1'b1;
                                err_pila = 1'b1;
                                st_next  = ST_ERR;
                            end
                        end
                        OPC_RET: begin
                            if (sp != '0) begin
                                s_ret = 1'b1;
                                pop   = 1'b1;
                            end else begin
                                // Underflow: nothing to return to.
                                pc_en    = 1'b0;
                                fin      = 1'b1;
                                err_pila = 1'b1;
                                st_next  = ST_ERR;
                            end
                        end
                        OPC_NOP: begin
                        end
                        default: begin
                            // HALT stops the PC in the cycle it is decoded.
                            pc_en   = 1'b0;
                            fin     = 1'b1;
                            st_next = ST_HALT;
                        end
                    endcase
                end
                ST_HALT: begin
                    pc_en = 1'b0;
                    fin   = 1'b1;
                end
                default: begin
                    // ST_ERR, and any unreachable encoding, behaves as a fault.
                    pc_en    = 1'b0;
                    fin      = 1'b1;
                    err_pila = 1'b1;
                    st_next  = ST_ERR;
                end
            endcase
        end
    end

    // Top-of-stack read: entry below the pointer, zero when the stack is empty.
    always_comb begin
        ret_addr = '0;
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (sp == SPW'(i + 1)) begin
                    ret_addr = stack[i];
                end
            end
        end
    end

    // State, stack pointer and stack storage update on the rising edge.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: the stack is small and ret_addr is visible on a port, so its
        // entries are cleared by reset to keep that output deterministic.
        if (reset) begin
            st <= ST_RUN;
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every register here sample
            // the pre-edge sp, so the push slot and the new sp stay consistent.
            st <= st_next;
            if (push) begin
                sp <= sp + SP_ONE;
            end else if (pop) begin
                sp <= sp - SP_ONE;
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (push && sp == SPW'(i)) begin
                    stack[i] <= pc_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_uc_pila.sv
// ----------------------------------------------------------------------------
// tb_uc_pila: table-driven bench for uc_pila (OPW=6, AW=10, DEPTH=4).
// Each table row is one clock cycle: inputs plus hand-derived expected outputs.
// Rows are pushed to a scoreboard queue when driven and popped when the
// outputs are sampled, mid-cycle, away from the rising edge.
// ----------------------------------------------------------------------------
module tb_uc_pila;

    localparam int OPW   = 6;
    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int SPW   = $clog2(DEPTH + 1);

    localparam logic [5:0] ALU5 = 6'b000101;
    localparam logic [5:0] LOAD = 6'b001000;
    localparam logic [5:0] JMP  = 6'b001001;
    localparam logic [5:0] JZ   = 6'b001010;
    localparam logic [5:0] JNZ  = 6'b001011;
    localparam logic [5:0] CALL = 6'b001100;
    localparam logic [5:0] RET  = 6'b001101;
    localparam logic [5:0] NOP  = 6'b001110;
    localparam logic [5:0] HALT = 6'b001111;

    typedef struct {
        int             id;
        logic           rst;
        logic [OPW-1:0] opc;
        logic           z;
        logic [AW-1:0]  pcn;
        logic           s_inc;
        logic           s_inm;
        logic           we3;
        logic [2:0]     op;
        logic           s_ret;
        logic [AW-1:0]  ret;
        logic           pc_en;
        logic           fin;
        logic           err;
        logic [SPW-1:0] niv;
    } vec_t;

    logic           clk;
    logic           reset;
    logic           z;
    logic [OPW-1:0] opcode;
    logic [AW-1:0]  pc_next;
    logic           s_inc;
    logic           s_inm;
    logic           we3;
    logic [2:0]     op;
    logic           s_ret;
    logic [AW-1:0]  ret_addr;
    logic           pc_en;
    logic           fin;
    logic           err_pila;
    logic [SPW-1:0] nivel;

    int   checks;
    int   errors;
    vec_t tbl[$];
    vec_t sb[$];

    uc_pila #(.OPW(OPW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .z        (z),
        .opcode   (opcode),
        .pc_next  (pc_next),
        .s_inc    (s_inc),
        .s_inm    (s_inm),
        .we3      (we3),
        .op       (op),
        .s_ret    (s_ret),
        .ret_addr (ret_addr),
        .pc_en    (pc_en),
        .fin      (fin),
        .err_pila (err_pila),
        .nivel    (nivel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Build one cycle record: inputs, then expected outputs.
    function automatic vec_t row(int rst, logic [OPW-1:0] opc, int zz, int pcn,
                                 int e_inc, int e_inm, int e_we3, int e_op,
                                 int e_ret, int e_addr, int e_pcen, int e_fin,
                                 int e_err, int e_niv);
        vec_t v;
        v.id    = 0;
        v.rst   = 1'(rst);
        v.opc   = opc;
        v.z     = 1'(zz);
        v.pcn   = AW'(pcn);
        v.s_inc = 1'(e_inc);
        v.s_inm = 1'(e_inm);
        v.we3   = 1'(e_we3);
        v.op    = 3'(e_op);
        v.s_ret = 1'(e_ret);
        v.ret   = AW'(e_addr);
        v.pc_en = 1'(e_pcen);
        v.fin   = 1'(e_fin);
        v.err   = 1'(e_err);
        v.niv   = SPW'(e_niv);
        return v;
    endfunction

    task automatic check(input string name, input int id,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, id, act, exp);
        end
    endtask

    // Pop the oldest expectation and compare every output against it.
    task automatic compare_outputs();
        vec_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries, expected 1");
            return;
        end
        e = sb.pop_front();
        check("s_inc",    e.id, 32'(s_inc),    32'(e.s_inc));
        check("s_inm",    e.id, 32'(s_inm),    32'(e.s_inm));
        check("we3",      e.id, 32'(we3),      32'(e.we3));
        check("op",       e.id, 32'(op),       32'(e.op));
        check("s_ret",    e.id, 32'(s_ret),    32'(e.s_ret));
        check("ret_addr", e.id, 32'(ret_addr), 32'(e.ret));
        check("pc_en",    e.id, 32'(pc_en),    32'(e.pc_en));
        check("fin",      e.id, 32'(fin),      32'(e.fin));
        check("err_pila", e.id, 32'(err_pila), 32'(e.err));
        check("nivel",    e.id, 32'(nivel),    32'(e.niv));
    endtask

    // Drive one cycle after the falling edge and sample before the rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        reset   = v.rst;
        opcode  = v.opc;
        z       = v.z;
        pc_next = v.pcn;
        sb.push_back(v);
        #2;
        compare_outputs();
    endtask

    initial begin
        vec_t v;
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        opcode  = NOP;
        z       = 1'b0;
        pc_next = '0;

        //              rst opc          z  pcn    inc inm we3 op ret addr   pcen fin err niv
        tbl.push_back(row(1, NOP,         0, 0,     1, 0, 0, 0, 0, 0,     0, 0, 0, 0));
        tbl.push_back(row(0, ALU5,        0, 0,     1, 0, 1, 5, 0, 0,     1, 0, 0, 0));
        tbl.push_back(row(0, ALU5,        1, 0,     1, 0, 1, 5, 0, 0,     1, 0, 0, 0));
        tbl.push_back(row(0, 6'b110011,   0, 0,     1, 0, 1, 3, 0, 0,     1, 0, 0, 0));
        tbl.push_back(row(0, LOAD,        0, 0,     1, 1, 1, 0, 0, 0,     1, 0, 0, 0));
        tbl.push_back(row(0, JMP,         0, 0,     0, 0, 0, 0, 0, 0,     1, 0, 0, 0));
        tbl.push_back(row(0, JZ,          1, 0,     0, 0, 0, 0, 0, 0,     1, 0, 0, 0));
        tbl.push_back(row(0, JZ,          0, 0,     1, 0, 0, 0, 0, 0,     1, 0, 0, 0));
        tbl.push_back(row(0, JNZ,         1, 0,     1, 0, 0, 0, 0, 0,     1, 0, 0, 0));
        tbl.push_back(row(0, JNZ,         0, 0,     0, 0, 0, 0, 0, 0,     1, 0, 0, 0));
        tbl.push_back(row(0, NOP,         1, 0,     1, 0, 0, 0, 0, 0,     1, 0, 0, 0));
        // Nested CALL/RET pair
        tbl.push_back(row(0, CALL,        0, 'h011, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0));
        tbl.push_back(row(0, CALL,        0, 'h022, 0, 0, 0, 0, 0, 'h011, 1, 0, 0, 1));
        tbl.push_back(row(0, RET,         0, 0,     1, 0, 0, 0, 1, 'h022, 1, 0, 0, 2));
        tbl.push_back(row(0, RET,         0, 0,     1, 0, 0, 0, 1, 'h011, 1, 0, 0, 1));
        tbl.push_back(row(0, NOP,         0, 0,     1, 0, 0, 0, 0, 0,     1, 0, 0, 0));
        // Underflow, then ERR is sticky until reset
        tbl.push_back(row(0, RET,         0, 0,     1, 0, 0, 0, 0, 0,     0, 1, 1, 0));
        tbl.push_back(row(0, NOP,         0, 0,     1, 0, 0, 0, 0, 0,     0, 1, 1, 0));
        tbl.push_back(row(0, ALU5,        0, 0,     1, 0, 0, 0, 0, 0,     0, 1, 1, 0));
        tbl.push_back(row(1, ALU5,        0, 0,     1, 0, 0, 0, 0, 0,     0, 0, 0, 0));
        tbl.push_back(row(0, 6'b000001,   0, 0,     1, 0, 1, 1, 0, 0,     1, 0, 0, 0));
        // Fill the stack, then overflow on the fifth CALL
        tbl.push_back(row(0, CALL,        0, 'h100, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0));
        tbl.push_back(row(0, CALL,        0, 'h101, 0, 0, 0, 0, 0, 'h100, 1, 0, 0, 1));
        tbl.push_back(row(0, 6'b111100,   0, 'h102, 0, 0, 0, 0, 0, 'h101, 1, 0, 0, 2));
        tbl.push_back(row(0, CALL,        0, 'h103, 0, 0, 0, 0, 0, 'h102, 1, 0, 0, 3));
        tbl.push_back(row(0, CALL,        0, 'h104, 1, 0, 0, 0, 0, 'h103, 0, 1, 1, 4));
        tbl.push_back(row(0, NOP,         0, 0,     1, 0, 0, 0, 0, 'h103, 0, 1, 1, 4));
        tbl.push_back(row(1, NOP,         0, 0,     1, 0, 0, 0, 0, 0,     0, 0, 0, 0));
        // HALT is immediate and sticky
        tbl.push_back(row(0, HALT,        0, 0,     1, 0, 0, 0, 0, 0,     0, 1, 0, 0));
        tbl.push_back(row(0, ALU5,        0, 0,     1, 0, 0, 0, 0, 0,     0, 1, 0, 0));
        tbl.push_back(row(0, CALL,        0, 'h1F0, 1, 0, 0, 0, 0, 0,     0, 1, 0, 0));
        tbl.push_back(row(1, NOP,         0, 0,     1, 0, 0, 0, 0, 0,     0, 0, 0, 0));
        // RET directly after CALL returns the just-pushed address
        tbl.push_back(row(0, CALL,        0, 'h2AA, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0));
        tbl.push_back(row(0, RET,         0, 0,     1, 0, 0, 0, 1, 'h2AA, 1, 0, 0, 1));
        tbl.push_back(row(0, NOP,         0, 0,     1, 0, 0, 0, 0, 0,     1, 0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            v    = tbl[i];
            v.id = i;
            apply(v);
        end

        // Asynchronous reset in the middle of a CALL cycle aborts the push.
        v = row(0, CALL, 0, 'h050, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0); v.id = 100; apply(v);
        v = row(0, CALL, 0, 'h051, 0, 0, 0, 0, 0, 'h050, 1, 0, 0, 1); v.id = 101; apply(v);
        @(negedge clk);
        opcode  = CALL;
        pc_next = 10'h052;
        v = row(0, CALL, 0, 'h052, 0, 0, 0, 0, 0, 'h051, 1, 0, 0, 2); v.id = 102;
        sb.push_back(v);
        #2;
        compare_outputs();
        #1;
        reset = 1'b1;
        v = row(1, CALL, 0, 'h052, 1, 0, 0, 0, 0, 0,     0, 0, 0, 0); v.id = 103;
        sb.push_back(v);
        #1;
        compare_outputs();
        @(posedge clk);
        #2;
        reset = 1'b0;
        v = row(0, NOP,  0, 0,     1, 0, 0, 0, 0, 0,     1, 0, 0, 0); v.id = 104; apply(v);
        v = row(0, CALL, 0, 'h060, 0, 0, 0, 0, 0, 0,     1, 0, 0, 0); v.id = 105; apply(v);
        v = row(0, RET,  0, 0,     1, 0, 0, 0, 1, 'h060, 1, 0, 0, 1); v.id = 106; apply(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
